// File: rtl/aux_period_gen.sv
// Paces aux FIFO reads against video timing, opens a fixed-length ADE window at the
// packet's target hcnt, streams the aux words out and counts ADE periods per line.
module aux_period_gen #(
    parameter int HW      = 11,
    parameter int DW      = 12,
    parameter int ADE_LEN = 32,
    parameter int NW      = 4
) (
    input  logic          fifo_clk,
    input  logic          sys_rst,
    input  logic [HW-1:0] hcnt,
    input  logic          vde,
    input  logic [DW-1:0] ax_dout,
    input  logic          ax_empty,
    output logic          ax_rd_en,
    output logic          ade,
    output logic [DW-1:0] aux_data,
    output logic          aux_valid,
    output logic [NW-1:0] ade_num,
    output logic          underflow
);

    localparam int SW = (ADE_LEN > 1) ? $clog2(ADE_LEN) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(ADE_LEN - 1);
    localparam logic [NW-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_ACTIVE
    } state_t;

    state_t        state_q,     state_d;
    logic [SW-1:0] slot_q,      slot_d;
    logic [HW-1:0] target_q,    target_d;
    logic          ade_q,       ade_d;
    logic          aux_valid_q, aux_valid_d;
    logic          underflow_q, underflow_d;
    logic          vde_dly_q,   vde_dly_d;
    logic [NW-1:0] line_cnt_q,  line_cnt_d;
    logic [NW-1:0] ade_num_q,   ade_num_d;
    logic [DW-1:0] hold_q,      hold_d;
    logic          rd_en;
    logic          period_done;
    logic          vde_rise;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        target_d    = target_q;
        underflow_d = underflow_q;
        rd_en       = 1'b0;
        period_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (vde) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!ax_empty) begin
                    rd_en   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Upper bits of the target word are reserved and dropped.
                target_d = ax_dout[HW-1:0];
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (!vde && (hcnt == target_q)) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                rd_en = !ax_empty;
                if (ax_empty) underflow_d = 1'b1;
                if (slot_q == SLOT_LAST) begin
                    slot_d      = '0;
                    period_done = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ade_d       = (state_d == S_ACTIVE);
        aux_valid_d = (state_q == S_ACTIVE) && rd_en;
        vde_dly_d   = vde;
        vde_rise    = vde && !vde_dly_q;
        ade_num_d   = ade_num_q;
        line_cnt_d  = line_cnt_q;
        // A period ending on the vde rising edge belongs to the new line.
        if (vde_rise) begin
            ade_num_d  = line_cnt_q;
            line_cnt_d = period_done ? NW'(1) : '0;
        end else if (period_done && (line_cnt_q != CNT_MAX)) begin
            line_cnt_d = line_cnt_q + 1'b1;
        end
    end

    // FIFO Q is valid the cycle after the read, so aux_data passes it straight through.
    always_comb begin
        aux_data = aux_valid_q ? ax_dout : hold_q;
        hold_d   = aux_data;
    end

    always_ff @(posedge fifo_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            target_q    <= '0;
            ade_q       <= 1'b0;
            aux_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            vde_dly_q   <= 1'b0;
            line_cnt_q  <= '0;
            ade_num_q   <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            target_q    <= target_d;
            ade_q       <= ade_d;
            aux_valid_q <= aux_valid_d;
            underflow_q <= underflow_d;
            vde_dly_q   <= vde_dly_d;
            line_cnt_q  <= line_cnt_d;
            ade_num_q   <= ade_num_d;
            hold_q      <= hold_d;
        end
    end

    assign ax_rd_en  = rd_en;
    assign ade       = ade_q;
    assign aux_valid = aux_valid_q;
    assign underflow = underflow_q;
    assign ade_num   = ade_num_q;

endmodule

// File: tb/tb_aux_period_gen.sv
// Directed bench for aux_period_gen: FIFO model, 1650-cycle line timing, monitor logs.
module tb_aux_period_gen;
    localparam int HW = 11, DW = 12, ADE_LEN = 32, NW = 4;

    logic          fifo_clk = 1'b0;
    logic          sys_rst  = 1'b1;
    logic [HW-1:0] hcnt     = '0;
    logic          vid_on   = 1'b0;
    logic          force_win = 1'b0;
    logic          vde, ax_empty, ax_rd_en, ade, aux_valid, underflow;
    logic [DW-1:0] ax_dout = '0;
    logic [DW-1:0] aux_data;
    logic [NW-1:0] ade_num;
    int            hi;

    logic [DW-1:0] mem [0:2047];
    int wp = 0, rp = 0;

    int n_cmp = 0, n_err = 0;
    int rd_cnt = 0, val_cnt = 0, rise_cnt = 0, ade_cyc = 0;
    logic ade_prev = 1'b0;
    int rd_h_log  [0:4095];
    int val_log   [0:4095];
    int rise_h_log[0:4095];

    aux_period_gen #(.HW(HW), .DW(DW), .ADE_LEN(ADE_LEN), .NW(NW)) dut (
        .fifo_clk (fifo_clk),
        .sys_rst  (sys_rst),
        .hcnt     (hcnt),
        .vde      (vde),
        .ax_dout  (ax_dout),
        .ax_empty (ax_empty),
        .ax_rd_en (ax_rd_en),
        .ade      (ade),
        .aux_data (aux_data),
        .aux_valid(aux_valid),
        .ade_num  (ade_num),
        .underflow(underflow)
    );

    always #5 fifo_clk = ~fifo_clk;

    assign hi       = int'(hcnt);
    assign vde      = vid_on && (hi >= 221) && (hi <= 1499);
    assign ax_empty = (wp == rp) || (force_win && (hi >= 1521) && (hi <= 1523));

    always @(posedge fifo_clk) begin
        hcnt <= (hi == 1649) ? '0 : hcnt + 1'b1;
        if (ax_rd_en) begin
            ax_dout <= mem[rp % 2048];
            rp      <= rp + 1;
        end
    end

    always @(negedge fifo_clk) begin
        if (ax_rd_en) begin
            rd_h_log[rd_cnt % 4096] = hi;
            rd_cnt++;
        end
        if (aux_valid) begin
            val_log[val_cnt % 4096] = int'(aux_data);
            val_cnt++;
        end
        if (ade) ade_cyc++;
        if (ade && !ade_prev) begin
            rise_h_log[rise_cnt % 4096] = hi;
            rise_cnt++;
        end
        ade_prev = ade;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        mem[wp % 2048] = DW'(v);
        wp++;
    endtask

    task automatic push_pkt(input int tgt, input int first, input int n);
        push(tgt);
        for (int i = 0; i < n; i++) push(first + i);
    endtask

    task automatic at_posedge();
        @(posedge fifo_clk);
        #1;
    endtask

    task automatic wait_h(input int h);
        int k;
        for (k = 0; k < 4000; k++) begin
            @(negedge fifo_clk);
            if (hi == h) break;
        end
        #1;
        if (k == 4000) begin
            n_cmp++;
            n_err++;
            $error("FAIL wait_h: observed timeout expected hcnt %0d", h);
        end
    endtask

    function automatic int seq_bad(input int base, input int first, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (val_log[(base + i) % 4096] != first + i) bad++;
        return bad;
    endfunction

    int b_rd, b_val, b_rise, b_cyc, hp, bad, pre;

    initial begin
        // Reset / idle: FIFO holds the basic packet, vde never rises.
        push_pkt(12'h5E6, 1, 32);
        repeat (3) @(posedge fifo_clk);
        @(negedge fifo_clk);
        #1 sys_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge fifo_clk);
            #1;
            if (ade || aux_valid || ax_rd_en || underflow || (ade_num != 0) || (aux_data != 0)) bad++;
        end
        chk("idle_outputs_nonzero_cycles", bad, 0);
        chk("idle_reads", rd_cnt, 0);
        chk("idle_aux_data", aux_data, 0);

        // Basic period, target 1510.
        wait_h(0);
        vid_on = 1'b1;
        b_rd = rd_cnt; b_val = val_cnt; b_rise = rise_cnt; b_cyc = ade_cyc;
        wait_h(1600);
        pre = 0;
        for (int i = b_rd; i < rd_cnt; i++) if (rd_h_log[i % 4096] < 1510) pre++;
        chk("basic_reads_before_1510", pre, 1);
        chk("basic_ade_rises", rise_cnt - b_rise, 1);
        chk("basic_ade_rise_hcnt", rise_h_log[b_rise % 4096], 1511);
        chk("basic_ade_cycles", ade_cyc - b_cyc, 32);
        chk("basic_valid_pulses", val_cnt - b_val, 32);
        chk("basic_data_seq_errors", seq_bad(b_val, 1, 32), 0);
        chk("basic_total_reads", rd_cnt - b_rd, 33);
        chk("basic_underflow", underflow, 0);
        chk("basic_ade_num_line0", ade_num, 0);

        // Empty stall in FETCH, then target 0x600.
        at_posedge();
        b_rd = rd_cnt;
        repeat (50) @(negedge fifo_clk);
        #1;
        chk("stall_reads_while_empty", rd_cnt - b_rd, 0);
        at_posedge();
        hp = hi;
        b_rd = rd_cnt; b_val = val_cnt; b_rise = rise_cnt; b_cyc = ade_cyc;
        push_pkt(12'h600, 12'h101, 32);
        wait_h(1600);
        chk("stall_first_read_hcnt", rd_h_log[b_rd % 4096], hp);
        chk("stall_ade_rise_hcnt", rise_h_log[b_rise % 4096], 1537);
        chk("stall_ade_cycles", ade_cyc - b_cyc, 32);
        chk("stall_data_seq_errors", seq_bad(b_val, 12'h101, 32), 0);
        chk("stall_total_reads", rd_cnt - b_rd, 33);
        chk("stall_ade_num", ade_num, 1);

        // Underflow: three empty slots (10..12) in a period at 1510.
        at_posedge();
        b_rd = rd_cnt; b_val = val_cnt; b_cyc = ade_cyc;
        push_pkt(12'h5E6, 12'h201, 29);
        force_win = 1'b1;
        wait_h(1520);
        chk("uf_underflow_before_empty", underflow, 0);
        wait_h(1600);
        force_win = 1'b0;
        chk("uf_ade_cycles", ade_cyc - b_cyc, 32);
        chk("uf_valid_pulses", val_cnt - b_val, 29);
        chk("uf_data_seq_errors", seq_bad(b_val, 12'h201, 29), 0);
        chk("uf_total_reads", rd_cnt - b_rd, 30);
        chk("uf_underflow_set", underflow, 1);

        // Two periods in one line, targets 1505 and 1560.
        at_posedge();
        b_rd = rd_cnt; b_val = val_cnt; b_rise = rise_cnt; b_cyc = ade_cyc;
        push_pkt(1505, 12'h301, 32);
        push_pkt(1560, 12'h321, 32);
        wait_h(1600);
        chk("multi_ade_rises", rise_cnt - b_rise, 2);
        chk("multi_rise1_hcnt", rise_h_log[b_rise % 4096], 1506);
        chk("multi_rise2_hcnt", rise_h_log[(b_rise + 1) % 4096], 1561);
        chk("multi_ade_cycles", ade_cyc - b_cyc, 64);
        chk("multi_data_seq_errors", seq_bad(b_val, 12'h301, 64), 0);
        chk("multi_total_reads", rd_cnt - b_rd, 66);
        chk("multi_underflow_sticky", underflow, 1);
        chk("multi_ade_num_prev_line", ade_num, 1);
        wait_h(300);
        chk("multi_ade_num", ade_num, 2);

        // Saturation: 17 periods with vde held low, then one vde rise.
        vid_on = 1'b0;
        wait_h(50);
        at_posedge();
        b_rise = rise_cnt;
        for (int p = 0; p < 17; p++) push_pkt(100 + 50 * p, 12'h400 + 32 * p, 32);
        wait_h(1000);
        chk("sat_ade_rises", rise_cnt - b_rise, 17);
        chk("sat_ade_num_before_rise", ade_num, 2);
        vid_on = 1'b1;
        wait_h(1010);
        chk("sat_ade_num", ade_num, 15);

        // Async reset at slot 10 of a period at 1550.
        at_posedge();
        push_pkt(1550, 12'h700, 32);
        wait_h(1561);
        chk("rst_pre_ade", ade, 1);
        chk("rst_pre_rd_en", ax_rd_en, 1);
        sys_rst = 1'b1;
        #1;
        chk("rst_ade", ade, 0);
        chk("rst_aux_valid", aux_valid, 0);
        chk("rst_rd_en", ax_rd_en, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_ade_num", ade_num, 0);
        chk("rst_aux_data", aux_data, 0);
        repeat (3) @(negedge fifo_clk);
        #1 sys_rst = 1'b0;
        b_rd = rd_cnt;
        wait_h(221);
        chk("rst_no_read_before_vde", rd_cnt - b_rd, 0);
        wait_h(223);
        chk("rst_read_after_vde", rd_cnt - b_rd, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
